dekatron_counter: RTL and testbench

- Parametrised multi-digit successor to the single-ring dekatron cell.
- Chain of DIGITS one-hot rings, each RING positions wide.
- Increment/decrement ripples carry/borrow digit by digit, one digit per clock, emulating dekatron pulse propagation.
- Used as a program/data counter in the dekatron PC datapath; supports parallel load, ready handshake, zero and carry flags.

---
 rtl/dekatron_counter.sv | 128 ++++++++++++
 tb/tb_dekatron_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dekatron_counter.sv
// rtl/dekatron_counter.sv - multi-digit one-hot ring counter with rippled carry/borrow
// Optional feature: DEKATRON_ONEHOT_CHECK_EN (one-hot correction of loaded digits, Error flag)
module dekatron_counter #(
  parameter int DIGITS = 3,
  parameter int RING   = 10
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Request,
  input  logic                     Dec,
  input  logic                     Set,
  input  logic [DIGITS*RING-1:0]   In,
  output logic [DIGITS*RING-1:0]   Out,
  output logic                     Ready,
  output logic                     Zero,
  output logic                     Carry
`ifdef DEKATRON_ONEHOT_CHECK_EN
  ,
  output logic                     Error
`endif
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RIPPLE} state_t;

  state_t                  state;
  logic [KW-1:0]           k;
  logic                    dir;
  logic [KW-1:0]           sel;
  logic                    down;
  logic [RING-1:0]         cur_digit;
  logic [RING-1:0]         next_digit;
  logic                    cur_wrap;
  logic [DIGITS*RING-1:0]  load_val;
`ifdef DEKATRON_ONEHOT_CHECK_EN
  logic                    load_err;
`endif

  // Only one digit moves per edge: digit 0 on an accepted op, digit k while rippling.
  always_comb begin
    sel        = (state == RIPPLE) ? k : '0;
    down       = (state == RIPPLE) ? dir : Dec;
    cur_digit  = Out[int'(sel)*RING +: RING];
    next_digit = down ? {cur_digit[0], cur_digit[RING-1:1]}
                      : {cur_digit[RING-2:0], cur_digit[RING-1]};
    cur_wrap   = down ? cur_digit[0] : cur_digit[RING-1];
  end

  always_comb begin
    load_val = In;
`ifdef DEKATRON_ONEHOT_CHECK_EN
    load_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if ($countones(In[d*RING +: RING]) != 1) begin
        load_val[d*RING +: RING] = RING'(1);
        load_err = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    Zero = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (Out[d*RING +: RING] != RING'(1)) Zero = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int d = 0; d < DIGITS; d++) Out[d*RING +: RING] <= RING'(1);
      state <= IDLE;
      Ready <= 1'b1;
      Carry <= 1'b0;
      k     <= '0;
      dir   <= 1'b0;
`ifdef DEKATRON_ONEHOT_CHECK_EN
      Error <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Request) begin
            Carry <= 1'b0;
            if (Set) begin
              Out <= load_val;
`ifdef DEKATRON_ONEHOT_CHECK_EN
              Error <= load_err;
`endif
            end else begin
              dir <= Dec;
              Out[0 +: RING] <= next_digit;
`ifdef DEKATRON_ONEHOT_CHECK_EN
              Error <= 1'b0;
`endif
              if (cur_wrap) begin
                if (DIGITS > 1) begin
                  state <= RIPPLE;
                  Ready <= 1'b0;
                  k     <= KW'(1);
                end else begin
                  Carry <= 1'b1;
                end
              end
            end
          end
        end
        RIPPLE: begin
          Out[int'(k)*RING +: RING] <= next_digit;
          if (cur_wrap && (k != KW'(DIGITS-1))) begin
            k <= k + KW'(1);
          end else begin
            // Wrapping out of the top digit is the overflow/borrow.
            if (cur_wrap) Carry <= 1'b1;
            state <= IDLE;
            Ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_counter.sv
// tb/tb_dekatron_counter.sv - self-checking bench for dekatron_counter (DIGITS=3, RING=10)
module tb_dekatron_counter;

  localparam int D = 3;
  localparam int R = 10;
  localparam int W = D * R;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Request = 1'b0;
  logic         Dec = 1'b0;
  logic         Set = 1'b0;
  logic [W-1:0] In = '0;
  logic [W-1:0] Out;
  logic         Ready;
  logic         Zero;
  logic         Carry;
`ifdef DEKATRON_ONEHOT_CHECK_EN
  logic         Error;
`endif

  int checks = 0;
  int errors = 0;

  dekatron_counter #(.DIGITS(D), .RING(R)) dut (
    .Clk(Clk), .Rst(Rst), .Request(Request), .Dec(Dec), .Set(Set), .In(In),
    .Out(Out), .Ready(Ready), .Zero(Zero), .Carry(Carry)
`ifdef DEKATRON_ONEHOT_CHECK_EN
    , .Error(Error)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Model: the counter is a decimal number; digits are an encoding of it.
  function automatic logic [W-1:0] enc(input int n);
    logic [W-1:0] v;
    int t;
    v = '0;
    t = n;
    for (int d = 0; d < D; d++) begin
      v[d*R +: R] = R'(1) << (t % R);
      t = t / R;
    end
    return v;
  endfunction

  function automatic int digit_of(input logic [W-1:0] v, input int d);
    for (int p = 0; p < R; p++) if (v[d*R + p]) return p;
    return 0;
  endfunction

  function automatic int decode(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int d = D - 1; d >= 0; d--) n = n * R + digit_of(v, d);
    return n;
  endfunction

  logic [W-1:0] m_out;
  int           m_busy;
  logic         m_carry;
  logic         m_err;
  logic         started = 1'b0;

  always @(posedge Clk) begin
    int n, w, modulus;
    logic stop;
    logic [W-1:0] lv;
    modulus = R ** D;
    if (Rst) begin
      m_out = enc(0); m_busy = 0; m_carry = 1'b0; m_err = 1'b0; started = 1'b1;
    end else if (started) begin
      if (m_busy > 0) begin
        m_busy--;
      end else if (Request) begin
        m_carry = 1'b0;
        if (Set) begin
          lv = In;
          m_err = 1'b0;
`ifdef DEKATRON_ONEHOT_CHECK_EN
          for (int d = 0; d < D; d++)
            if ($countones(In[d*R +: R]) != 1) begin lv[d*R +: R] = R'(1); m_err = 1'b1; end
`endif
          m_out = lv;
        end else begin
          m_err = 1'b0;
          n = decode(m_out);
          w = 0;
          stop = 1'b0;
          for (int d = 0; d < D; d++) begin
            if (!stop && (Dec ? digit_of(m_out, d) == 0 : digit_of(m_out, d) == R - 1)) w++;
            else stop = 1'b1;
          end
          m_busy  = (w == 0) ? 0 : ((w < D) ? w : D - 1);
          m_carry = (w == D);
          m_out   = enc(Dec ? (n + modulus - 1) % modulus : (n + 1) % modulus);
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (started && !Rst) begin
      chk("ready", Ready, m_busy == 0);
      if (m_busy == 0) begin
        chk("out", Out, m_out);
        chk("carry", Carry, m_carry);
        chk("zero", Zero, m_out == enc(0));
`ifdef DEKATRON_ONEHOT_CHECK_EN
        chk("error", Error, m_err);
`endif
      end
    end
  end

  task automatic op(input logic dec, input logic set, input logic [W-1:0] val);
    @(negedge Clk);
    Request = 1'b1; Dec = dec; Set = set; In = val;
    @(negedge Clk);
    Request = 1'b0; Set = 1'b0; Dec = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!Ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("rst_out", Out, 30'h0010_0401);
    chk("rst_ready", Ready, 1'b1);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_carry", Carry, 1'b0);

    // Nine back-to-back increments, then the tenth ripples into digit 1.
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0; Set = 1'b0;
    repeat (9) begin
      @(negedge Clk);
      chk("burst_ready", Ready, 1'b1);
    end
    Request = 1'b0;
    chk("nine_out", Out, 30'h0010_0600);
    op(1'b0, 1'b0, '0);
    chk("wrap_ready_low", Ready, 1'b0);
    wait_ready(n);
    chk("ripple1_len", n, 1);
    chk("ten_out", Out, 30'h0010_0801);
    chk("ten_carry", Carry, 1'b0);

    // 999 + 1 overflows through all digits.
    op(1'b0, 1'b1, 30'h2008_0200);
    chk("load999", Out, 30'h2008_0200);
    op(1'b0, 1'b0, '0);
    wait_ready(n);
    chk("ripple2_len", n, 2);
    chk("ovf_out", Out, 30'h0010_0401);
    chk("ovf_zero", Zero, 1'b1);
    chk("ovf_carry", Carry, 1'b1);
    op(1'b0, 1'b0, '0);
    chk("after_ovf", Out, 30'h0010_0402);
    chk("after_ovf_carry", Carry, 1'b0);

    // 000 - 1 borrows through to 999, then 998 without a ripple.
    Rst = 1'b1; @(negedge Clk); Rst = 1'b0;
    op(1'b1, 1'b0, '0);
    wait_ready(n);
    chk("borrow_len", n, 2);
    chk("borrow_out", Out, 30'h2008_0200);
    chk("borrow_carry", Carry, 1'b1);
    op(1'b1, 1'b0, '0);
    chk("dec998_ready", Ready, 1'b1);
    chk("dec998", Out, 30'h2008_0100);

    // A load attempted during a ripple is dropped.
    op(1'b0, 1'b1, 30'h0018_0200);
    @(negedge Clk);
    Request = 1'b1; Dec = 1'b0; Set = 1'b0;
    @(negedge Clk);
    Set = 1'b1; In = 30'h0200_8020;
    @(negedge Clk);
    Request = 1'b0; Set = 1'b0;
    wait_ready(n);
    chk("ignored_load", Out, 30'h0020_0401);

    // Reset during a ripple aborts it.
    op(1'b0, 1'b1, 30'h2008_0200);
    @(negedge Clk);
    Request = 1'b1;
    @(negedge Clk);
    Request = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("midrst_out", Out, 30'h0010_0401);
    chk("midrst_ready", Ready, 1'b1);
    chk("midrst_carry", Carry, 1'b0);

    // Non-one-hot digit on load.
    op(1'b0, 1'b1, 30'h0010_0C01);
`ifdef DEKATRON_ONEHOT_CHECK_EN
    chk("fix_out", Out, 30'h0010_0401);
    chk("fix_err", Error, 1'b1);
    op(1'b0, 1'b0, '0);
    chk("err_clear", Error, 1'b0);
`else
    chk("raw_out", Out, 30'h0010_0C01);
`endif

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
